// File: rtl/debug_pkg.sv
// Shared definitions for the debug controller: FSM states, dump sub-phases,
// host command opcodes and the program terminator word.
package debug_pkg;

    typedef enum logic [2:0] {
        RECVPROG, RECVMODE, RUNSTEP, RUNALL, SENDPC, SENDDM, SENDRB, SENDCLK
    } state_t;

    // PH_ADDR gives the memory a cycle to see a new address before PH_LOAD samples it
    typedef enum logic [1:0] {PH_ADDR, PH_LOAD, PH_BUSY} phase_t;

    localparam logic [3:0] CMD_STEP = 4'h1;
    localparam logic [3:0] CMD_RUN  = 4'h2;
    localparam logic [3:0] CMD_BP   = 4'h3;
    localparam logic [3:0] CMD_PROG = 4'h4;

    localparam logic [63:0] END_MARK = '1;

    function automatic logic is_send(input state_t s);
        return s inside {SENDPC, SENDDM, SENDRB, SENDCLK};
    endfunction

endpackage

// File: rtl/debug_ctrl_bp_if.sv
// Bundle of UART, CPU-control and memory-port signals between the debug
// controller (master) and the surrounding CPU/UART environment (slave).
interface debug_ctrl_bp_if #(
    parameter int IM_ADDR_LENGTH = 32,
    parameter int RBITS          = 5,
    parameter int NBITS          = 32
) ();
    logic [NBITS-1:0]          rx_Data;
    logic                      rx_done;
    logic                      tx_done;
    logic                      halt_flag;
    logic [NBITS-1:0]          current_PC;
    logic [NBITS-1:0]          clock_count;
    logic [NBITS-1:0]          RB_Data;
    logic [NBITS-1:0]          DM_Data;
    logic [IM_ADDR_LENGTH-1:0] IM_Addr;
    logic [NBITS-1:0]          IM_Data;
    logic                      IM_We;
    logic [RBITS-1:0]          RB_Addr;
    logic [NBITS-1:0]          DM_Addr;
    logic [NBITS-1:0]          tx_Data;
    logic                      tx_start;
    logic                      clock_enable;
    logic                      o_rst;
    logic                      prog_ovf;

    modport master (
        input  rx_Data, rx_done, tx_done, halt_flag, current_PC, clock_count, RB_Data, DM_Data,
        output IM_Addr, IM_Data, IM_We, RB_Addr, DM_Addr, tx_Data, tx_start,
               clock_enable, o_rst, prog_ovf
    );

    modport slave (
        output rx_Data, rx_done, tx_done, halt_flag, current_PC, clock_count, RB_Data, DM_Data,
        input  IM_Addr, IM_Data, IM_We, RB_Addr, DM_Addr, tx_Data, tx_start,
               clock_enable, o_rst, prog_ovf
    );
endinterface

// File: rtl/dbg_tx_seq.sv
// One-word transmit handshake: latch a word, pulse tx_start, hold the word
// until tx_done; tx_done with nothing pending is ignored.
module dbg_tx_seq #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [NBITS-1:0] word,
    input  logic             tx_done,
    output logic [NBITS-1:0] tx_data,
    output logic             tx_start,
    output logic             done
);
    logic pending;

    assign done = pending && tx_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data  <= '0;
            tx_start <= 1'b0;
            pending  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (load) begin
                tx_data  <= word;
                tx_start <= 1'b1;
                pending  <= 1'b1;
            end else if (done) begin
                pending <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/debug_ctrl_bp.sv
// Debug controller: loads a program over UART, runs/steps the CPU, then dumps
// PC, data memory, register bank and cycle count. Breakpoint command 0x3 is
// enabled by defining DBG_BREAKPOINT_EN.
module debug_ctrl_bp
    import debug_pkg::*;
#(
    parameter int IM_ADDR_LENGTH = 32,
    parameter int IM_MEM_SIZE    = 5,
    parameter int DM_MEM_SIZE    = 2,
    parameter int RBITS          = 5,
    parameter int RB_COUNT       = 32,
    parameter int NBITS          = 32
) (
    input  logic clk,
    input  logic reset,
    debug_ctrl_bp_if.master bus
);
    localparam int DM_WORDS = 2 ** DM_MEM_SIZE;
    localparam int IDXW     = $clog2((DM_WORDS > RB_COUNT ? DM_WORDS : RB_COUNT) + 1);
    localparam logic [IDXW-1:0]      DM_LAST = IDXW'(DM_WORDS - 1);
    localparam logic [IDXW-1:0]      RB_LAST = IDXW'(RB_COUNT - 1);
    localparam logic [IM_MEM_SIZE:0] IM_FULL = {1'b1, {IM_MEM_SIZE{1'b0}}};

    state_t                    state;
    phase_t                    ph;
    logic [IM_MEM_SIZE:0]      index;
    logic [IDXW-1:0]           idx;
    logic                      run_step;
    logic                      bp_hit;
    logic                      load;
    logic                      word_done;
    logic [NBITS-1:0]          word;
    logic [3:0]                cmd;
    logic [IM_ADDR_LENGTH-1:0] im_addr;
    logic [NBITS-1:0]          im_data;
    logic                      im_we;
    logic [RBITS-1:0]          rb_addr;
    logic [NBITS-1:0]          dm_addr;
    logic [NBITS-1:0]          tx_data;
    logic                      tx_start;
    logic                      clock_enable;
    logic                      o_rst;
    logic                      prog_ovf;

    assign cmd = bus.rx_Data[NBITS-1 -: 4];

`ifdef DBG_BREAKPOINT_EN
    logic [NBITS-1:0] bp_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bp_addr <= '0;
        else if (state == RECVMODE && bus.rx_done && cmd == CMD_BP)
            bp_addr <= NBITS'(bus.rx_Data[27:0]);
    end

    assign bp_hit = (bus.current_PC == bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    always_comb begin
        word = '0;
        unique case (state)
            SENDPC:  word = bus.current_PC;
            SENDDM:  word = bus.DM_Data;
            SENDRB:  word = bus.RB_Data;
            SENDCLK: word = bus.clock_count;
            default: word = '0;
        endcase
    end

    assign load = is_send(state) && (ph == PH_LOAD);

    dbg_tx_seq #(.NBITS(NBITS)) u_tx (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .word     (word),
        .tx_done  (bus.tx_done),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .done     (word_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RECVPROG;
            ph           <= PH_ADDR;
            index        <= '0;
            idx          <= '0;
            run_step     <= 1'b0;
            im_addr      <= '0;
            im_data      <= '0;
            im_we        <= 1'b0;
            rb_addr      <= '0;
            dm_addr      <= '0;
            clock_enable <= 1'b0;
            o_rst        <= 1'b0;
            prog_ovf     <= 1'b0;
        end else begin
            im_we <= 1'b0;
            o_rst <= 1'b0;
            if (is_send(state)) begin
                if (ph == PH_ADDR)      ph <= PH_LOAD;
                else if (ph == PH_LOAD) ph <= PH_BUSY;
            end
            unique case (state)
                RECVPROG: if (bus.rx_done) begin
                    if (bus.rx_Data == END_MARK[NBITS-1:0]) begin
                        o_rst <= 1'b1;
                        index <= '0;
                        state <= RECVMODE;
                    end else if (index == IM_FULL) begin
                        prog_ovf <= 1'b1;
                    end else begin
                        im_we   <= 1'b1;
                        im_data <= bus.rx_Data;
                        im_addr <= IM_ADDR_LENGTH'({index, 2'b00});
                        index   <= index + 1'b1;
                    end
                end
                RECVMODE: if (bus.rx_done) begin
                    case (cmd)
                        CMD_STEP: begin state <= RUNSTEP; clock_enable <= 1'b1; end
                        CMD_RUN:  begin state <= RUNALL;  clock_enable <= 1'b1; end
`ifdef DBG_BREAKPOINT_EN
                        CMD_BP:   begin state <= RUNALL;  clock_enable <= 1'b1; end
`endif
                        CMD_PROG: begin state <= RECVPROG; prog_ovf <= 1'b0; index <= '0; end
                        default: ;
                    endcase
                end
                RUNSTEP: begin
                    clock_enable <= 1'b0;
                    run_step     <= !bus.halt_flag;
                    state        <= SENDPC;
                    ph           <= PH_LOAD;
                end
                // halt wins over a simultaneous breakpoint: the run then ends in RECVPROG
                RUNALL: if (bus.halt_flag || bp_hit) begin
                    clock_enable <= 1'b0;
                    run_step     <= !bus.halt_flag;
                    state        <= SENDPC;
                    ph           <= PH_LOAD;
                end
                SENDPC: if (word_done) begin
                    state   <= SENDDM;
                    dm_addr <= '0;
                    idx     <= '0;
                    ph      <= PH_ADDR;
                end
                SENDDM: if (word_done) begin
                    ph <= PH_ADDR;
                    if (idx == DM_LAST) begin
                        state   <= SENDRB;
                        rb_addr <= '0;
                        idx     <= '0;
                    end else begin
                        idx     <= idx + 1'b1;
                        dm_addr <= NBITS'({idx + 1'b1, 2'b00});
                    end
                end
                SENDRB: if (word_done) begin
                    if (idx == RB_LAST) begin
                        state <= SENDCLK;
                        ph    <= PH_LOAD;
                    end else begin
                        idx     <= idx + 1'b1;
                        rb_addr <= RBITS'(idx + 1'b1);
                        ph      <= PH_ADDR;
                    end
                end
                SENDCLK: if (word_done) begin
                    ph <= PH_ADDR;
                    if (run_step) begin
                        state <= RECVMODE;
                    end else begin
                        state    <= RECVPROG;
                        prog_ovf <= 1'b0;
                        index    <= '0;
                    end
                end
                default: state <= RECVPROG;
            endcase
        end
    end

    assign bus.IM_Addr      = im_addr;
    assign bus.IM_Data      = im_data;
    assign bus.IM_We        = im_we;
    assign bus.RB_Addr      = rb_addr;
    assign bus.DM_Addr      = dm_addr;
    assign bus.tx_Data      = tx_data;
    assign bus.tx_start     = tx_start;
    assign bus.clock_enable = clock_enable;
    assign bus.o_rst        = o_rst;
    assign bus.prog_ovf     = prog_ovf;
endmodule

// File: tb/tb_debug_ctrl_bp.sv
// Directed bench for debug_ctrl_bp: program load, step, run-to-halt, overflow,
// breakpoint (when DBG_BREAKPOINT_EN is defined) and reset mid-dump.
module tb_debug_ctrl_bp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_assert = 0;
    int n_fail = 0;
    int ce_cnt = 0;
    int orst_cnt = 0;
    logic [31:0] txq[$];
    logic [63:0] imq[$];

    debug_ctrl_bp_if #(.IM_ADDR_LENGTH(32), .RBITS(5), .NBITS(32)) bus ();

    debug_ctrl_bp #(
        .IM_ADDR_LENGTH(32), .IM_MEM_SIZE(5), .DM_MEM_SIZE(2),
        .RBITS(5), .RB_COUNT(32), .NBITS(32)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // registered-read memories with address-tagged contents
    always @(posedge clk) begin
        bus.DM_Data <= 32'hD000_0000 | bus.DM_Addr;
        bus.RB_Data <= 32'hB000_0000 | 32'(bus.RB_Addr);
    end

    always @(posedge clk) begin
        if (bus.IM_We === 1'b1) imq.push_back({bus.IM_Addr, bus.IM_Data});
        if (bus.clock_enable === 1'b1) ce_cnt++;
        if (bus.o_rst === 1'b1) orst_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // UART transmitter model: acknowledge each word two cycles after tx_start
    always begin : tx_resp
        logic [31:0] w;
        @(posedge clk);
        if (bus.tx_start === 1'b1) begin
            w = bus.tx_Data;
            @(posedge clk);
            chk("tx_start_pulse", 64'(bus.tx_start), 64'd0);
            @(negedge clk);
            if (rst_n) chk("tx_data_hold", 64'(bus.tx_Data), 64'(w));
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
            txq.push_back(w);
        end
    end

    function automatic logic [31:0] tx_at(input int i);
        return (i < txq.size()) ? txq[i] : 32'hx;
    endfunction

    function automatic logic [63:0] im_at(input int i);
        return (i < imq.size()) ? imq[i] : 64'hx;
    endfunction

    task automatic send_rx(input logic [31:0] w);
        @(negedge clk);
        bus.rx_Data = w;
        bus.rx_done = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
    endtask

    task automatic chk_idle(input string t);
        chk({t, "_IM_Addr"},      64'(bus.IM_Addr), 0);
        chk({t, "_IM_Data"},      64'(bus.IM_Data), 0);
        chk({t, "_IM_We"},        64'(bus.IM_We), 0);
        chk({t, "_RB_Addr"},      64'(bus.RB_Addr), 0);
        chk({t, "_DM_Addr"},      64'(bus.DM_Addr), 0);
        chk({t, "_tx_Data"},      64'(bus.tx_Data), 0);
        chk({t, "_tx_start"},     64'(bus.tx_start), 0);
        chk({t, "_clock_enable"}, 64'(bus.clock_enable), 0);
        chk({t, "_o_rst"},        64'(bus.o_rst), 0);
        chk({t, "_prog_ovf"},     64'(bus.prog_ovf), 0);
    endtask

    task automatic expect_dump(input logic [31:0] pc, input logic [31:0] cc);
        int c = 0;
        while (txq.size() < 38 && c < 1500) begin
            @(negedge clk);
            c++;
        end
        chk("dump_words", 64'(txq.size()), 64'd38);
        chk("dump_pc", 64'(tx_at(0)), 64'(pc));
        for (int i = 0; i < 4; i++)
            chk($sformatf("dump_dm%0d", i), 64'(tx_at(1 + i)), 64'(32'hD000_0000 | (i * 4)));
        for (int i = 0; i < 32; i++)
            chk($sformatf("dump_rb%0d", i), 64'(tx_at(5 + i)), 64'(32'hB000_0000 | i));
        chk("dump_clk", 64'(tx_at(37)), 64'(cc));
        repeat (3) @(negedge clk);
        txq.delete();
    endtask

    initial begin
        bus.rx_Data     = '0;
        bus.rx_done     = 1'b0;
        bus.tx_done     = 1'b0;
        bus.halt_flag   = 1'b0;
        bus.current_PC  = 32'h2;
        bus.clock_count = 32'h3;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;

        // program load
        send_rx(32'h0000_00FF);
        send_rx(32'h0000_000F);
        repeat (2) @(negedge clk);
        chk("load_count", 64'(imq.size()), 2);
        chk("load_w0", im_at(0), {32'h0, 32'hFF});
        chk("load_w1", im_at(1), {32'h4, 32'h0F});
        send_rx(32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        chk("end_orst", 64'(orst_cnt), 1);
        chk("end_no_write", 64'(imq.size()), 2);

        // single step
        ce_cnt = 0;
        send_rx(32'h1000_1000);
        expect_dump(32'h2, 32'h3);
        chk("step_ce", 64'(ce_cnt), 1);
        chk("step_no_write", 64'(imq.size()), 2);

        // run until halt, raised four cycles after the command
        ce_cnt = 0;
        bus.current_PC  = 32'h44;
        bus.clock_count = 32'h1234;
        send_rx(32'h2000_0000);
        repeat (3) @(negedge clk);
        bus.halt_flag = 1'b1;
        expect_dump(32'h44, 32'h1234);
        bus.halt_flag = 1'b0;
        chk("run_ce", 64'(ce_cnt), 4);
        chk("run_ce_low", 64'(bus.clock_enable), 0);

        // back in RECVPROG: fill memory and overflow it
        imq.delete();
        for (int i = 0; i < 32; i++) send_rx(32'h100 + i);
        repeat (2) @(negedge clk);
        chk("fill_count", 64'(imq.size()), 32);
        chk("fill_first", im_at(0), {32'h0, 32'h100});
        chk("fill_last", im_at(31), {32'h7C, 32'h11F});
        chk("fill_no_ovf", 64'(bus.prog_ovf), 0);
        send_rx(32'h0000_DEAD);
        repeat (2) @(negedge clk);
        chk("ovf_dropped", 64'(imq.size()), 32);
        chk("ovf_set", 64'(bus.prog_ovf), 1);
        orst_cnt = 0;
        send_rx(32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        chk("ovf_end_orst", 64'(orst_cnt), 1);

        // unknown command is ignored; reload command clears overflow
        ce_cnt = 0;
        send_rx(32'h5000_0000);
        repeat (10) @(negedge clk);
        chk("badcmd_ce", 64'(ce_cnt), 0);
        chk("badcmd_tx", 64'(txq.size()), 0);
        chk("badcmd_im", 64'(imq.size()), 32);
        chk("ovf_sticky", 64'(bus.prog_ovf), 1);
        send_rx(32'h4000_0000);
        repeat (2) @(negedge clk);
        chk("ovf_cleared", 64'(bus.prog_ovf), 0);
        send_rx(32'h0000_0077);
        repeat (2) @(negedge clk);
        chk("reload_count", 64'(imq.size()), 33);
        chk("reload_addr0", im_at(32), {32'h0, 32'h77});
        send_rx(32'hFFFF_FFFF);
        repeat (2) @(negedge clk);

`ifdef DBG_BREAKPOINT_EN
        ce_cnt = 0;
        bus.current_PC  = 32'h0;
        bus.clock_count = 32'h55;
        send_rx(32'h3000_0008);
        for (int c = 0; c < 10; c++) begin
            if (bus.clock_enable === 1'b1) bus.current_PC = bus.current_PC + 32'd4;
            @(negedge clk);
        end
        chk("bp_ce", 64'(ce_cnt), 2);
        expect_dump(32'h8, 32'h55);
        ce_cnt = 0;
        bus.current_PC  = 32'h2;
        bus.clock_count = 32'h3;
        send_rx(32'h1000_1000);
        expect_dump(32'h2, 32'h3);
        chk("bp_then_step_ce", 64'(ce_cnt), 1);
`else
        ce_cnt = 0;
        imq.delete();
        send_rx(32'h3000_0008);
        repeat (20) @(negedge clk);
        chk("nobp_ce", 64'(ce_cnt), 0);
        chk("nobp_tx", 64'(txq.size()), 0);
        chk("nobp_im", 64'(imq.size()), 0);
`endif

        // reset in the middle of the register dump
        bus.current_PC  = 32'h2;
        bus.clock_count = 32'h3;
        send_rx(32'h1000_1000);
        for (int c = 0; c < 600 && txq.size() < 8; c++) @(negedge clk);
        chk("reach_rb", 64'(txq.size() >= 8), 1);
        rst_n = 1'b0;
        #1;
        chk_idle("midrst");
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        imq.delete();
        txq.delete();
        send_rx(32'h0000_00AB);
        repeat (2) @(negedge clk);
        chk("post_rst_count", 64'(imq.size()), 1);
        chk("post_rst_w0", im_at(0), {32'h0, 32'hAB});
        repeat (10) @(negedge clk);
        chk("post_rst_no_tx", 64'(txq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end
endmodule
